// File: rtl/vec_pkg.sv
// Shared vector typedefs for the execute-to-writeback path.
// Lane/vector shapes, the buffered entry and the buffer state.
package vec_pkg;

    localparam int regSize  = 8;
    localparam int vecSize  = 16;
    localparam int regAddrW = 4;

    typedef logic [regSize-1:0] lane_t;
    typedef lane_t [vecSize-1:0] vec_t;

    typedef struct packed {
        vec_t                result;
        logic [regAddrW-1:0] dest;
        logic                we;
    } ex_wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/vector_ex_wb_buffer.sv
// Two-entry elastic buffer between vector execute and writeback.
// in_ready comes from registered state only; head feeds the bypass.
module vector_ex_wb_buffer
    import vec_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  vec_t                in_result,
    input  logic [regAddrW-1:0] in_dest,
    input  logic                in_we,
    output logic                out_valid,
    input  logic                out_ready,
    output vec_t                out_result,
    output logic [regAddrW-1:0] out_dest,
    output logic                out_we,
    output logic                fwd_valid,
    output logic [regAddrW-1:0] fwd_dest,
    output vec_t                fwd_result
);

    buf_state_e   state_q;
    buf_state_e   state_d;
    ex_wb_entry_t head_q;
    ex_wb_entry_t tail_q;
    ex_wb_entry_t in_entry;

    logic accept;
    logic pop;
    logic head_from_in;
    logic head_from_tail;
    logic tail_from_in;

    assign in_entry = '{result: in_result, dest: in_dest, we: in_we};

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        head_from_in   = 1'b0;
        head_from_tail = 1'b0;
        tail_from_in   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    head_from_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_from_in = 1'b1;
                end else if (accept) begin
                    state_d      = FULL;
                    tail_from_in = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d        = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // flush beats any same-cycle accept or pop
        if (flush) begin
            state_d        = EMPTY;
            head_from_in   = 1'b0;
            head_from_tail = 1'b0;
            tail_from_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            if (head_from_in) begin
                head_q <= in_entry;
            end else if (head_from_tail) begin
                head_q <= tail_q;
            end
            if (tail_from_in) begin
                tail_q <= in_entry;
            end
        end
    end

    assign out_result = head_q.result;
    assign out_dest   = head_q.dest;
    assign out_we     = head_q.we;

    assign fwd_valid  = out_valid & head_q.we;
    assign fwd_dest   = head_q.dest;
    assign fwd_result = head_q.result;

endmodule

// File: doc/vector_ex_wb_buffer.md
# vector_ex_wb_buffer

Two-entry elastic pipeline buffer between the vector execute stage and writeback. It captures lane-wise execute results, such as the vectorized XOR output, together with destination metadata. It decouples execute from register-file write stalls with a valid/ready handshake and provides a forwarding view of the oldest pending result to the operand bypass network.

## Interface
- regSize, 8, bits per lane
- vecSize, 16, lanes per vector
- regAddrW, 4, vector register index width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all buffered and incoming results
- in_valid  in  1  execute presents a result
- in_ready  out  1  buffer can accept this cycle
- in_result  in  [regSize-1:0] x vecSize  lane results
- in_dest  in  regAddrW  destination vector register
- in_we  in  1  result must be written (0 = bubble-type op, carried but not written)
- out_valid  out  1  head entry available to writeback
- out_ready  in  1  writeback consumes head this cycle
- out_result  out  [regSize-1:0] x vecSize  head entry lanes
- out_dest  out  regAddrW  head destination
- out_we  out  1  head write enable
- fwd_valid  out  1  head valid and out_we=1
- fwd_dest  out  regAddrW  equals out_dest
- fwd_result  out  [regSize-1:0] x vecSize  equals out_result

## Operation
- Storage: 2 entries, head (slot 0) and tail (slot 1), each holding {result, dest, we}.
- State machine: EMPTY (0 entries), ONE (head only), FULL (head and tail).
- Accept = in_valid & in_ready; Pop = out_valid & out_ready.
- EMPTY: accept -> ONE, input written to head.
- ONE: accept only -> FULL, input to tail; pop only -> EMPTY; accept and pop -> ONE, input to head.
- FULL: pop -> ONE, tail moves to head; no accept is possible because in_ready=0.
- in_ready = (state != FULL), driven from a registered state only and never from out_ready, so there is no combinational ready path through the block.
- out_valid = (state != EMPTY). Outputs reflect the head registers directly.
- Entries with in_we=0 occupy slots and are popped normally. fwd_valid is 0 for them.
- Order is strictly FIFO. No lane data is modified, and widths pass through unchanged.
- flush: next state EMPTY. Any accept or pop in the same cycle is ignored, and flush wins over both.
- Data registers need no reset. state resets to EMPTY.

## Timing
- Reset (async assert, sync-released by the top level): state=EMPTY, out_valid=0, fwd_valid=0, in_ready=1. Data outputs are don't-care but must not be X-propagated into valid.
- Latency: accept at edge N gives out_valid=1 from edge N+1 onward, when the buffer was EMPTY.
- Throughput: 1 result per cycle sustained while out_ready=1.
- Once out_ready drops, at most 2 results are held. in_ready falls the cycle after the second accept.
- Pop from FULL at edge N gives in_ready=1 after edge N.
- Outputs are stable while out_valid=1 and out_ready=0, and out_valid is never retracted without a pop or a flush.
- Reset assertion mid-operation clears state immediately, asynchronously. Buffered results are lost.

## Structure
- A shared package `vec_pkg` holds the lane and vector typedefs (`lane_t`, `vec_t` built from regSize/vecSize), a packed `ex_wb_entry_t` {vec_t result; logic [regAddrW-1:0] dest; logic we;}, and the state enum `buf_state_e` {EMPTY, ONE, FULL}.
- No sub-module: a single always_ff for state and entries plus an always_comb for next state and handshakes.

## Test plan
- Reset, then one transfer: after rst_n is deasserted, push result lanes 0x00..0x0F to dest 3 with out_ready=1 -> out_valid high for exactly 1 cycle with identical lanes and dest=3; fwd_valid=1 in the same cycle.
- Backpressure fill: out_ready=0, push A(dest1) then B(dest2) -> in_ready=0 after the second accept. A third push on the next cycle is not accepted. Releasing out_ready -> A then B in order.
- Simultaneous push and pop in ONE: stream 8 results with out_ready=1 throughout -> 8 consecutive out_valid cycles, order preserved, in_ready always 1.
- Flush while FULL with in_valid=1 -> the next cycle shows out_valid=0 and in_ready=1. Neither the buffered entries nor the flushed input ever appears at the output.
- we=0 entry: push {we=0, dest 5} -> out_valid=1, out_we=0, fwd_valid=0, popped normally.
- Async reset mid-stream while FULL: drop rst_n between clock edges -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
